mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 123 ++++++++++++
 tb/tb_mem_copy_dma.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - word-by-word memory copy engine (RD/LAT/WR per word)
// Optional fill mode under macro DMA_FILL_EN.
module mem_copy_dma #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
`ifdef DMA_FILL_EN
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_val,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] src_q, src_n;
  logic [AW-1:0] dst_q, dst_n;
  logic [AW-1:0] cnt_q, cnt_n;
  logic [DW-1:0] data_q, data_n;
  logic          fill_q, fill_n;
  logic [DW-1:0] fval_q, fval_n;
  logic          we_q;
  logic          fill_in;
  logic [DW-1:0] fval_in;

`ifdef DMA_FILL_EN
  assign fill_in = fill_mode;
  assign fval_in = fill_val;
`else
  assign fill_in = 1'b0;
  assign fval_in = '0;
`endif

  // A reset edge must not let an in-flight write reach the memory.
  assign mem_we = we_q && !rst;

  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    cnt_n   = cnt_q;
    data_n  = data_q;
    fill_n  = fill_q;
    fval_n  = fval_q;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_n   = src;
            dst_n   = dst;
            cnt_n   = len;
            fill_n  = fill_in;
            fval_n  = fval_in;
            state_n = fill_in ? WR : RD;
          end else begin
            state_n = FIN;
          end
        end
      end
      RD:  state_n = LAT;
      LAT: begin
        data_n  = mem_dout;
        state_n = WR;
      end
      WR: begin
        src_n = src_q + 1'b1;
        dst_n = dst_q + 1'b1;
        cnt_n = cnt_q - 1'b1;
        if (cnt_n != '0) state_n = fill_q ? WR : RD;
        else             state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      fill_q   <= 1'b0;
      fval_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we_q     <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state  <= state_n;
      src_q  <= src_n;
      dst_q  <= dst_n;
      cnt_q  <= cnt_n;
      data_q <= data_n;
      fill_q <= fill_n;
      fval_q <= fval_n;
      busy   <= (state_n != IDLE);
      done   <= (state == FIN);
      we_q   <= (state_n == WR);
      if (state_n == RD || state_n == LAT) mem_addr <= src_n;
      else if (state_n == WR)              mem_addr <= dst_n;
      else                                 mem_addr <= '0;
      if (state_n == WR) mem_din <= fill_n ? fval_n : data_n;
      else               mem_din <= '0;
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb/tb_mem_copy_dma.sv - directed and random checks of mem_copy_dma against a copy model
module tb_mem_copy_dma;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] src, dst, len;
  logic        busy, done, mem_we;
  logic [15:0] mem_addr, mem_din, mem_dout;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [15:0] fill_val;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_copy_dma #(.DW(16), .AW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
`ifdef DMA_FILL_EN
    .fill_mode(fill_mode), .fill_val(fill_val),
`endif
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as their own address.
  logic [15:0] mem [int];
  logic [15:0] ref_mem [int];
  logic [15:0] rd_log [$];
  int          wr_count = 0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : a;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a;
  endfunction

  always @(posedge clk) begin
    if (busy && !mem_we) rd_log.push_back(mem_addr);
    mem_dout <= mem_rd(mem_addr);
    if (mem_we) begin
      mem[int'(mem_addr)] = mem_din;
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer; restart_at>0 pulses start again (other src) in that cycle.
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input bit fm, input logic [15:0] fv, input int restart_at);
    int w0, k, done_cyc, exp_cyc, bad;
    logic [15:0] a;
    w0 = wr_count;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
`ifdef DMA_FILL_EN
    fill_mode = fm; fill_val = fv;
`endif
    @(posedge clk); #1;
    start = 1'b0; src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
`ifdef DMA_FILL_EN
    fill_mode = 1'($urandom); fill_val = 16'($urandom);
`endif
    chk("busy_cycle1", int'(busy), 1);
    k = 1;
    done_cyc = -1;
    while (k < 400) begin
      if (done) begin
        done_cyc = k;
        break;
      end
      if (k == restart_at) begin
        start = 1'b1; src = s ^ 16'h0F0F; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (l == 0)  exp_cyc = 2;
    else if (fm) exp_cyc = int'(l) + 2;
    else         exp_cyc = 3 * int'(l) + 2;
    chk("done_cycle", done_cyc, exp_cyc);
    chk("writes", wr_count - w0, int'(l));
    for (int i = 0; i < int'(l); i++) begin
      a = s + 16'(i);
      ref_mem[int'(d + 16'(i))] = fm ? fv : ref_rd(a);
    end
    bad = 0;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 16'(i);
      if (mem_rd(a) !== ref_rd(a)) bad++;
    end
    chk("data_words_wrong", bad, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_addr_din", int'({mem_addr, mem_din, 15'd0, busy}), 0);
  endtask

  initial begin
    int base, w0, saw_done;
    logic [15:0] s, d, l;
    logic [15:0] wrap_exp [4];
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0; fill_val = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({busy, done, mem_we}), 0);
    chk("reset_addr", int'(mem_addr), 0);
    chk("reset_din", int'(mem_din), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic copy with fixed window checks.
    run_xfer(16'h0010, 16'h0020, 16'd4, 1'b0, 16'h0, 0);
    for (int i = 0; i < 4; i++) chk("copy_word", int'(mem_rd(16'h0020 + 16'(i))), 16'h0010 + i);

    // Zero length.
    run_xfer(16'h1234, 16'h4321, 16'd0, 1'b0, 16'h0, 0);

    // Source wrap: each source address is held for RD and LAT.
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    base = rd_log.size();
    run_xfer(16'hFFFE, 16'h0200, 16'd4, 1'b0, 16'h0, 0);
    for (int i = 0; i < 4; i++) chk("wrap_read", int'(rd_log[base + 2 * i]), int'(wrap_exp[i]));

    // Start again mid-transfer must be ignored.
    run_xfer(16'h0300, 16'h0400, 16'd5, 1'b0, 16'h0, 4);
    chk("restart_word4", int'(mem_rd(16'h0404)), int'(ref_rd(16'h0304)));

    // GPIO-mapped words and overlapping ascending copy.
    run_xfer(16'h00FE, 16'h0100, 16'd4, 1'b0, 16'h0, 0);
    run_xfer(16'h0500, 16'h0502, 16'd6, 1'b0, 16'h0, 0);
    chk("overlap_word", int'(mem_rd(16'h0506)), int'(ref_rd(16'h0502)));

    for (int t = 0; t < 6; t++) begin
      s = 16'($urandom);
      d = 16'($urandom);
      l = 16'($urandom_range(1, 12));
      if (t == 0) d = s + 16'd1;
      run_xfer(s, d, l, 1'b0, 16'h0, 0);
    end

    // Reset during the second write of a 4-word copy.
    w0 = wr_count;
    @(negedge clk);
    start = 1'b1; src = 16'h0040; dst = 16'h0050; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("second_wr_we", int'(mem_we), 1);
    chk("second_wr_addr", int'(mem_addr), 16'h0051);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_writes", wr_count - w0, 1);
    ref_mem[16'h0050] = ref_rd(16'h0040);
    chk("abort_word0", int'(mem_rd(16'h0050)), int'(ref_rd(16'h0050)));
    chk("abort_word1", int'(mem_rd(16'h0051)), int'(ref_rd(16'h0051)));

    // Engine still usable after abort.
    run_xfer(16'h0600, 16'h0700, 16'd2, 1'b0, 16'h0, 0);

`ifdef DMA_FILL_EN
    run_xfer(16'h0000, 16'h0030, 16'd3, 1'b1, 16'hA5A5, 0);
    for (int i = 0; i < 3; i++) chk("fill_word", int'(mem_rd(16'h0030 + 16'(i))), 16'hA5A5);
    run_xfer(16'($urandom), 16'($urandom), 16'($urandom_range(1, 9)), 1'b1, 16'($urandom), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
